fpu_lzc_norm_pipe: RTL

- Two-stage pipelined leading/trailing-one detector with a normalizing shifter, for FPU mantissa normalization after add/sub and for int-to-float conversion.
- Per transaction, counts leading zeros (MSB side) or trailing zeros (LSB side). Returns the count, an all-zero flag, and the operand shifted so the first one lands on the MSB (leading mode) or on bit 0 (trailing mode).
- Valid/ready handshake on both sides, with a sideband tag carried through unchanged.

---
 rtl/fpu_lzc_norm_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fpu_lzc_norm_pipe.sv
// Two-stage leading/trailing-zero counter with normalizing shifter for FPU mantissas.
// Stage 1 finds the first one; stage 2 shifts the operand and drives the outputs.
module fpu_lzc_norm_pipe #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             mode_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CW-1:0]    cnt_o,
  output logic             no_ones_o,
  output logic [WIDTH-1:0] data_o,
  output logic [TAG_W-1:0] tag_o
);

  // Search vector is padded up to a power of two; padding leaves stay zero.
  localparam int P = 1 << CW;

  // Lowest set bit of v by halving the window at each level: if the lower
  // half is empty the answer lies in the upper half and that count bit is set.
  function automatic logic [CW-1:0] first_one(input logic [P-1:0] v);
    logic [P-1:0]  w;
    logic [P-1:0]  m;
    logic [CW-1:0] c;
    w = v;
    c = '0;
    for (int b = CW - 1; b >= 0; b--) begin
      m = {P{1'b1}} >> (P - (1 << b));
      if ((w & m) == '0) begin
        c[b] = 1'b1;
        w    = w >> (1 << b);
      end
    end
    return c;
  endfunction

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_data, s2_data;
  logic             s1_mode;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [CW-1:0]    s1_cnt, s2_cnt;
  logic             s1_no_ones, s2_no_ones;

  logic             s1_adv, s2_adv;
  logic [P-1:0]     search_v;
  logic [CW-1:0]    cnt_in;
  logic             no_ones_in;
  logic [WIDTH-1:0] shifted;

  assign s2_adv  = ~s2_valid | ready_i;
  assign s1_adv  = ~s1_valid | s2_adv;
  assign ready_o = s1_adv & ~rst_i;

  // Leading mode searches the bit-reversed operand so one search serves both modes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    search_v   = '0;
    no_ones_in = ~|data_i;
    if (mode_i) begin
      search_v[WIDTH-1:0] = data_i;
    end else begin
      for (int i = 0; i < WIDTH; i++) search_v[i] = data_i[WIDTH-1-i];
    end
    cnt_in = no_ones_in ? '0 : first_one(search_v);
  end

  always_comb begin
    shifted = s1_mode ? (s1_data >> s1_cnt) : (s1_data << s1_cnt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: datapath registers are reset as well because the outputs must read zero out of reset.
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_mode    <= 1'b0;
      s1_tag     <= '0;
      s1_cnt     <= '0;
      s1_no_ones <= 1'b0;
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_tag     <= '0;
      s2_cnt     <= '0;
      s2_no_ones <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data    <= shifted;
          s2_tag     <= s1_tag;
          s2_cnt     <= s1_cnt;
          s2_no_ones <= s1_no_ones;
        end
      end
      if (s1_adv) begin
        s1_valid <= valid_i;
        if (valid_i) begin
          s1_data    <= data_i;
          s1_mode    <= mode_i;
          s1_tag     <= tag_i;
          s1_cnt     <= cnt_in;
          s1_no_ones <= no_ones_in;
        end
      end
    end
  end

  assign valid_o   = s2_valid;
  assign data_o    = s2_data;
  assign cnt_o     = s2_cnt;
  assign no_ones_o = s2_no_ones;
  assign tag_o     = s2_tag;

endmodule
